attack_shot_state: RTL
======================

Name: attack_shot_state

Overview:
- Firing-phase controller; the reader of the board that the ship-placement state writes.
- On entry it snapshots the placed enemy board, then accepts fire-button presses at the cursor (i_actual, j_actual).
- Each shot resolves to hit, miss or error; the block updates its board copy, counts remaining ships, and flags game over.
- Sits beside the placement state under the game FSM; its board output drives the VGA renderer.

Parameters:
- BOARD_N, 5, board rows and columns.
- CNT_W, 3, width of the ship counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- attack_State  in  1  high while the game FSM is in the firing phase.
- i_actual  in  3  cursor row.
- j_actual  in  3  cursor column.
- initial_ships_count  in  CNT_W  ships on the board at phase entry; each ship is one cell.
- fire_button  in  1  synchronised level; a rising edge is one shot.
- tablero_enemigo  in  2 x [BOARD_N][BOARD_N]  placed board (AGUA/BARCO only).
- tablero_enemigo_out  out  2 x [BOARD_N][BOARD_N]  registered board with shot marks.
- shot_hit  out  1  one-cycle pulse.
- shot_miss  out  1  one-cycle pulse.
- shot_error  out  1  one-cycle pulse.
- turn_done  out  1  one-cycle pulse on a valid shot.
- ships_remaining  out  CNT_W  registered counter.
- all_sunk  out  1  level, game over.

Behaviour:
- Cell encoding: AGUA=00, BARCO=01, TOCADO=10 (hit), FALLO=11 (miss).
- Reset (rst=0, asynchronous):
  - board all AGUA; ships_remaining=0.
  - all pulses 0; all_sunk=0.
  - state S_IDLE; edge-detector register 0.
- States: S_IDLE, S_LOAD, S_WAIT, S_EVAL, S_OVER.
- S_IDLE: attack_State=1 -> S_LOAD.
- S_LOAD (one cycle):
  - copy tablero_enemigo into the board register; ships_remaining <= initial_ships_count.
  - initial_ships_count=0 -> S_OVER; otherwise -> S_WAIT.
  - A fire edge arriving in S_LOAD is discarded; the edge detector still updates, so a held button never fires later.
- S_WAIT:
  - A fire rising edge (fire_button=1, fire_q=0) sampled at clock edge N latches i/j and moves to S_EVAL.
- S_EVAL, at edge N+1:
  - row or column >= BOARD_N: shot_error=1, no update, -> S_WAIT.
  - cell TOCADO or FALLO: shot_error=1, no update, no turn_done, -> S_WAIT (player fires again).
  - cell BARCO: cell <= TOCADO; shot_hit=1; turn_done=1; ships_remaining-1 (saturates at 0).
    - new value 0 -> S_OVER with all_sunk=1; otherwise -> S_WAIT.
  - cell AGUA: cell <= FALLO; shot_miss=1; turn_done=1; -> S_WAIT.
- Latency and pulse rules:
  - Pulses and the board update are visible from edge N+1 for exactly one cycle.
  - Exactly one of hit/miss/error fires per shot.
  - Minimum 2 cycles between accepted shots.
- S_OVER:
  - all_sunk held at 1; fire ignored; board frozen.
  - attack_State=0 -> S_IDLE.
- attack_State=0 in any state:
  - next edge -> S_IDLE; pending shot abandoned; pulses 0.
  - Board, ships_remaining and all_sunk retained until the next S_LOAD, which clears all_sunk.
- tablero_enemigo is only read in S_LOAD; later changes to it have no effect.

Decomposition:
- Package battleship_pkg:
  - cell_t enum (AGUA, BARCO, TOCADO, FALLO).
  - BOARD_N.
  - board_t (cell_t [BOARD_N][BOARD_N]).
  - state_t enum for this block.
- Shared with the placement state and the VGA renderer.
- Sub-module: rising_edge_detect (clk, rst, in, pulse) for fire_button.

Test Plan:
- Reset then load:
  - Stimulus: board with BARCO at (2,1), (0,0), (4,4); initial_ships_count=3; attack_State=1.
  - Required: after the S_LOAD cycle, output board equals input and ships_remaining=3.
- Hit:
  - Stimulus: cursor (2,1), press fire.
  - Required: shot_hit=1 and turn_done=1 for one cycle, 2 edges after the press; cell(2,1)=10; ships_remaining=2.
- Miss then repeat:
  - Stimulus: cursor (1,3), fire twice.
  - Required: first press gives shot_miss and cell=11; second gives shot_error with no turn_done and the board unchanged.
- Out of range and held button:
  - Stimulus: cursor (5,0), fire; then hold fire high for 10 cycles.
  - Required: one shot_error only; no update.
- Game over:
  - Stimulus: hit (0,0), then (4,4).
  - Required: ships_remaining=0; all_sunk=1; further presses give no pulses.
  - Then: deassert and reassert attack_State with count 0; all_sunk=1 right after S_LOAD.
- Mid-operation abort:
  - Stimulus: drop attack_State on the cycle after a press, or pull rst low during S_EVAL.
  - Required: no pulses.
  - On the attack_State drop: board kept.
  - On reset: board all 00, ships_remaining=0.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared battleship types: cell encoding, board geometry and the firing-phase FSM states.
// Used by the placement state, the firing state and the VGA renderer.
package battleship_pkg;

   localparam int BOARD_N = 5;

   typedef enum logic [1:0] {
      AGUA   = 2'b00,
      BARCO  = 2'b01,
      TOCADO = 2'b10,
      FALLO  = 2'b11
   } cell_t;

   typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_WAIT = 3'd2,
      S_EVAL = 3'd3,
      S_OVER = 3'd4
   } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle pulse on a 0->1 transition of an already synchronised level.
module rising_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) in_q <= 1'b0;
      else      in_q <= in;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/attack_shot_state.sv
// Firing-phase controller: snapshots the placed enemy board, resolves fire presses at the
// cursor into hit/miss/error, keeps the marked board and the remaining-ship count.
module attack_shot_state
   import battleship_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             attack_State,
   input  logic [2:0]       i_actual,
   input  logic [2:0]       j_actual,
   input  logic [CNT_W-1:0] initial_ships_count,
   input  logic             fire_button,
   input  board_t           tablero_enemigo,
   output board_t           tablero_enemigo_out,
   output logic             shot_hit,
   output logic             shot_miss,
   output logic             shot_error,
   output logic             turn_done,
   output logic [CNT_W-1:0] ships_remaining,
   output logic             all_sunk
);

   localparam logic [2:0] LIM = 3'(BOARD_N);

   state_t           state_q, state_d;
   board_t           board_q, board_d;
   logic [CNT_W-1:0] ships_q, ships_d, ships_dec;
   logic [2:0]       row_q, row_d, col_q, col_d;
   logic             sunk_q, sunk_d;
   logic             hit_q, hit_d, miss_q, miss_d, err_q, err_d, done_q, done_d;
   logic             fire_pulse, in_range;
   cell_t            cur;

   rising_edge_detect u_fire_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (fire_button),
      .pulse (fire_pulse)
   );

   assign in_range  = (row_q < LIM) && (col_q < LIM);
   assign cur       = in_range ? board_q[row_q][col_q] : AGUA;
   assign ships_dec = (ships_q == '0) ? '0 : ships_q - CNT_W'(1);

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      ships_d = ships_q;
      sunk_d  = sunk_q;
      row_d   = row_q;
      col_d   = col_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      // Leaving the phase abandons any pending shot but keeps the board for the renderer.
      if (!attack_State) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
               board_d = tablero_enemigo;
               ships_d = initial_ships_count;
               sunk_d  = (initial_ships_count == '0);
               state_d = (initial_ships_count == '0) ? S_OVER : S_WAIT;
            end
            S_WAIT: begin
               if (fire_pulse) begin
                  row_d   = i_actual;
                  col_d   = j_actual;
                  state_d = S_EVAL;
               end
            end
            S_EVAL: begin
               state_d = S_WAIT;
               if (!in_range) begin
                  err_d = 1'b1;
               end else begin
                  case (cur)
                     BARCO: begin
                        board_d[row_q][col_q] = TOCADO;
                        hit_d   = 1'b1;
                        done_d  = 1'b1;
                        ships_d = ships_dec;
                        if (ships_dec == '0) begin
                           sunk_d  = 1'b1;
                           state_d = S_OVER;
                        end
                     end
                     AGUA: begin
                        board_d[row_q][col_q] = FALLO;
                        miss_d = 1'b1;
                        done_d = 1'b1;
                     end
                     default: err_d = 1'b1;  // already-shot cell: player fires again
                  endcase
               end
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         for (int r = 0; r < BOARD_N; r++)
            for (int c = 0; c < BOARD_N; c++)
               board_q[r][c] <= AGUA;
         ships_q <= '0;
         row_q   <= '0;
         col_q   <= '0;
         sunk_q  <= 1'b0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         ships_q <= ships_d;
         row_q   <= row_d;
         col_q   <= col_d;
         sunk_q  <= sunk_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign tablero_enemigo_out = board_q;
   assign ships_remaining     = ships_q;
   assign all_sunk            = sunk_q;
   assign shot_hit            = hit_q;
   assign shot_miss           = miss_q;
   assign shot_error          = err_q;
   assign turn_done           = done_q;

endmodule
